cpu_test_ctrl: RTL and testbench
================================

// Module: cpu_test_ctrl
// PURPOSE
//  Synthesizable test-harness controller that sits beside the cpu instance in simulation and FPGA benches.
//  Sequences the CPU reset, runs a cycle watchdog and a no-retire hang detector, and decodes end-of-test stores to TOHOST_ADDR.
//  Reports PASS/FAIL/TIMEOUT/HANG with counters. Replaces ad-hoc watchdog/reset tasks; supports rerun without global reset.
// PARAMETERS
//  CPU_WIDTH    32          data/address width of the monitored store bus
//  CNT_WIDTH    32          width of cycle/retire counters (saturating)
//  RST_CYCLES   4           cycles cpu_reset_n is held low after entering RESET (>=1)
//  WDOG_LIMIT   10000       RUN cycles before TIMEOUT (0 = watchdog disabled)
//  STALL_LIMIT  256         consecutive RUN cycles with no retire before HANG (0 = disabled)
//  TOHOST_ADDR  32'h8000_1000  store address signalling end of test
// PORTS
//  clk           in   1          system clock
//  a_reset_n     in   1          async active-low reset
//  rerun         in   1          pulse: restart test from RESET (honoured only in DONE)
//  retire_valid  in   1          CPU retired one instruction this cycle
//  store_valid   in   1          CPU store accepted this cycle
//  store_addr    in   CPU_WIDTH  store address
//  store_data    in   CPU_WIDTH  store data
//  cpu_reset_n   out  1          reset to cpu, active low
//  done          out  1          high while in DONE
//  status        out  3          test_status_e (see package)
//  fail_code     out  CPU_WIDTH-1  store_data>>1 on FAIL, else 0
//  cycle_count   out  CNT_WIDTH  RUN cycles elapsed
//  retire_count  out  CNT_WIDTH  instructions retired in RUN
// BEHAVIOUR
//  Reset (a_reset_n=0): state=RESET, cpu_reset_n=0, done=0, status=ST_IDLE, fail_code=0, all counters=0.
//  States: RESET -> RUN -> DONE; DONE -> RESET on rerun.
//  RESET: rst_cnt counts 0..RST_CYCLES-1 with cpu_reset_n=0; on the last count go to RUN next edge.
//   cpu_reset_n rises registered, on the first RUN cycle; never combinational from a_reset_n.
//  RUN: status=ST_RUNNING; cycle_count+1 every cycle; retire_count+1 per retire_valid; both saturate at all-ones.
//   stall_cnt clears on retire_valid, else +1.
//  End-of-test store, store_valid && store_addr==TOHOST_ADDR:
//   store_data==1 -> DONE/ST_PASS.
//   store_data!=1 -> DONE/ST_FAIL, fail_code=store_data[CPU_WIDTH-1:1].
//   Stores to other addresses are ignored.
//  TIMEOUT: WDOG_LIMIT!=0 and cycle_count reaches WDOG_LIMIT-1 in RUN -> DONE/ST_TIMEOUT.
//  HANG: STALL_LIMIT!=0 and stall_cnt reaches STALL_LIMIT-1 with no retire that cycle -> DONE/ST_HANG.
//  Simultaneous events in one cycle, priority: tohost store > HANG > TIMEOUT. The cycle's retire is still counted.
//  Terminal-cycle update: the status, done and frozen counters are all registered on the same edge.
//  DONE: done=1, cpu_reset_n=0 (CPU held), counters and status frozen; store/retire inputs ignored.
//  rerun outside DONE: ignored.
//  rerun in DONE: next edge state=RESET, counters/fail_code cleared, status=ST_IDLE, done=0.
//  a_reset_n asserted mid-RUN: immediate async return to reset values; no status retained.
// STRUCTURE
//  Package cpu_test_pkg:
//   typedef enum logic[1:0] {S_RESET, S_RUN, S_DONE} tc_state_e.
//   typedef enum logic[2:0] {ST_IDLE, ST_RUNNING, ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG} test_status_e.
//   localparam TOHOST_PASS = 1.
//  One sub-module sat_counter #(W) (clr, inc, q, saturating), instanced for cycle, retire and stall counts.
//  FSM, tohost decode and priority logic stay in this module.
// TESTING
//  1 Reset: RST_CYCLES=4, release a_reset_n -> cpu_reset_n low exactly 4 clk, high on 5th; status=ST_RUNNING.
//  2 Pass: store 1 to TOHOST_ADDR at RUN cycle 50 with 40 retires -> next edge done=1, ST_PASS, cycle_count=51, retire_count=40.
//  3 Fail: store 32'h0000_0007 to TOHOST_ADDR -> ST_FAIL, fail_code=3; a store of 1 to TOHOST_ADDR-4 has no effect.
//  4 Timeout: WDOG_LIMIT=100, retire every cycle, no tohost -> ST_TIMEOUT, cycle_count=100, cpu_reset_n=0.
//  5 Hang vs priority: STALL_LIMIT=8, no retire -> ST_HANG after 8 RUN cycles; tohost store on that same cycle -> ST_PASS.
//  6 Rerun/mid-reset: rerun in DONE -> counters 0, new 4-cycle reset, reruns; a_reset_n low mid-RUN -> all outputs reset at once.

Source files
------------

// File: rtl/cpu_test_pkg.sv
// Shared types for the CPU test-harness controller: FSM states, reported test status
// and the tohost value that signals a passing test.
package cpu_test_pkg;

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_DONE
    } tc_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT,
        ST_HANG
    } test_status_e;

    localparam int TOHOST_PASS = 1;

endpackage

// File: rtl/cpu_test_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cpu_test_ctrl.sv
// Test-harness controller: sequences CPU reset, watches for tohost end-of-test stores,
// and ends the run on PASS/FAIL, watchdog timeout or a no-retire hang.
module cpu_test_ctrl
    import cpu_test_pkg::*;
#(
    parameter int                   CPU_WIDTH   = 32,
    parameter int                   CNT_WIDTH   = 32,
    parameter int                   RST_CYCLES  = 4,
    parameter int                   WDOG_LIMIT  = 10000,
    parameter int                   STALL_LIMIT = 256,
    parameter logic [CPU_WIDTH-1:0] TOHOST_ADDR = 32'h8000_1000
) (
    input  logic                 clk,
    input  logic                 a_reset_n,
    input  logic                 rerun,
    input  logic                 retire_valid,
    input  logic                 store_valid,
    input  logic [CPU_WIDTH-1:0] store_addr,
    input  logic [CPU_WIDTH-1:0] store_data,
    output logic                 cpu_reset_n,
    output logic                 done,
    output logic [2:0]           status,
    output logic [CPU_WIDTH-2:0] fail_code,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retire_count
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    tc_state_e             state_q;
    test_status_e          status_q;
    logic                  cpu_reset_n_q;
    logic                  done_q;
    logic [CPU_WIDTH-2:0]  fail_code_q;
    logic [RW-1:0]         rst_cnt_q;

    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic                  in_run;
    logic                  rerun_go;
    logic                  tohost_hit;
    logic                  hang_hit;
    logic                  wdog_hit;
    logic                  term_d;
    test_status_e          term_status_d;

    assign in_run   = (state_q == S_RUN);
    assign rerun_go = (state_q == S_DONE) && rerun;

    assign tohost_hit = in_run && store_valid && (store_addr == TOHOST_ADDR);
    assign hang_hit   = (STALL_LIMIT != 0) && in_run && !retire_valid
                        && (stall_cnt == CNT_WIDTH'(STALL_LIMIT - 1));
    assign wdog_hit   = (WDOG_LIMIT != 0) && in_run
                        && (cycle_count == CNT_WIDTH'(WDOG_LIMIT - 1));

    // tohost store outranks hang, which outranks the watchdog
    always_comb begin
        term_d        = 1'b0;
        term_status_d = ST_RUNNING;
        if (tohost_hit) begin
            term_d        = 1'b1;
            term_status_d = (store_data == CPU_WIDTH'(TOHOST_PASS)) ? ST_PASS : ST_FAIL;
        end else if (hang_hit) begin
            term_d        = 1'b1;
            term_status_d = ST_HANG;
        end else if (wdog_hit) begin
            term_d        = 1'b1;
            term_status_d = ST_TIMEOUT;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (a_reset_n),
        .clr   (rerun_go || (state_q == S_RESET)),
        .inc   (in_run),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_retire_cnt (
        .clk   (clk),
        .rst_n (a_reset_n),
        .clr   (rerun_go || (state_q == S_RESET)),
        .inc   (in_run && retire_valid),
        .q     (retire_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (a_reset_n),
        .clr   (!in_run || retire_valid),
        .inc   (1'b1),
        .q     (stall_cnt)
    );

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q       <= S_RESET;
            status_q      <= ST_IDLE;
            cpu_reset_n_q <= 1'b0;
            done_q        <= 1'b0;
            fail_code_q   <= '0;
            rst_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                        state_q       <= S_RUN;
                        status_q      <= ST_RUNNING;
                        cpu_reset_n_q <= 1'b1;
                        rst_cnt_q     <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (term_d) begin
                        state_q       <= S_DONE;
                        status_q      <= term_status_d;
                        done_q        <= 1'b1;
                        cpu_reset_n_q <= 1'b0;
                        fail_code_q   <= (term_status_d == ST_FAIL)
                                         ? store_data[CPU_WIDTH-1:1] : '0;
                    end
                end
                S_DONE: begin
                    if (rerun) begin
                        state_q     <= S_RESET;
                        status_q    <= ST_IDLE;
                        done_q      <= 1'b0;
                        fail_code_q <= '0;
                        rst_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_RESET;
                end
            endcase
        end
    end

    assign cpu_reset_n = cpu_reset_n_q;
    assign done        = done_q;
    assign status      = status_q;
    assign fail_code   = fail_code_q;

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Directed bench for cpu_test_ctrl: a table of end-of-test scenarios plus hand-written
// sequences for reset timing, watchdog, hang, priority, rerun and asynchronous reset.
module tb_cpu_test_ctrl;
    import cpu_test_pkg::*;

    localparam logic [31:0] TOHOST = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        a_reset_n = 1'b0;
    logic        rerun = 1'b0;
    logic        retire_valid = 1'b0;
    logic        store_valid = 1'b0;
    logic [31:0] store_addr = '0;
    logic [31:0] store_data = '0;

    logic        crn_a, done_a, crn_t, done_t, crn_h, done_h;
    logic [2:0]  status_a, status_t, status_h;
    logic [30:0] fc_a, fc_t, fc_h;
    logic [31:0] cc_a, rc_a, cc_t, rc_t, cc_h, rc_h;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Default build: tables, reset, rerun and async reset
    cpu_test_ctrl u_dut_a (
        .clk(clk), .a_reset_n(a_reset_n), .rerun(rerun), .retire_valid(retire_valid),
        .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
        .cpu_reset_n(crn_a), .done(done_a), .status(status_a), .fail_code(fc_a),
        .cycle_count(cc_a), .retire_count(rc_a)
    );

    // Watchdog and stall limits coincide so HANG-over-TIMEOUT priority is visible
    cpu_test_ctrl #(.WDOG_LIMIT(100), .STALL_LIMIT(100)) u_dut_t (
        .clk(clk), .a_reset_n(a_reset_n), .rerun(rerun), .retire_valid(retire_valid),
        .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
        .cpu_reset_n(crn_t), .done(done_t), .status(status_t), .fail_code(fc_t),
        .cycle_count(cc_t), .retire_count(rc_t)
    );

    cpu_test_ctrl #(.WDOG_LIMIT(0), .STALL_LIMIT(8)) u_dut_h (
        .clk(clk), .a_reset_n(a_reset_n), .rerun(rerun), .retire_valid(retire_valid),
        .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
        .cpu_reset_n(crn_h), .done(done_h), .status(status_h), .fail_code(fc_h),
        .cycle_count(cc_h), .retire_count(rc_h)
    );

    typedef struct {
        int          n;
        int          r;
        logic        ret_on_store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  exp_status;
        logic [30:0] exp_fc;
        int          exp_cc;
        int          exp_rc;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rerun        = 1'b0;
        retire_valid = 1'b0;
        store_valid  = 1'b0;
        store_addr   = '0;
        store_data   = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        a_reset_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic start_run();
        apply_reset();
        a_reset_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic tohost_store(input logic [31:0] addr, input logic [31:0] data);
        store_valid = 1'b1;
        store_addr  = addr;
        store_data  = data;
    endtask

    initial begin
        int cnt;
        int cc_snap;

        vecs[0] = '{n: 50, r: 40, ret_on_store: 1'b0, addr: TOHOST, data: 32'h1,
                    exp_status: ST_PASS, exp_fc: 31'h0, exp_cc: 51, exp_rc: 40};
        vecs[1] = '{n: 10, r: 10, ret_on_store: 1'b1, addr: TOHOST, data: 32'h7,
                    exp_status: ST_FAIL, exp_fc: 31'h3, exp_cc: 11, exp_rc: 11};
        vecs[2] = '{n: 3, r: 0, ret_on_store: 1'b0, addr: TOHOST, data: 32'hFFFF_FFFE,
                    exp_status: ST_FAIL, exp_fc: 31'h7FFF_FFFF, exp_cc: 4, exp_rc: 0};
        vecs[3] = '{n: 0, r: 0, ret_on_store: 1'b1, addr: TOHOST, data: 32'h0,
                    exp_status: ST_FAIL, exp_fc: 31'h0, exp_cc: 1, exp_rc: 1};

        // Reset values and the 4-cycle CPU reset window
        apply_reset();
        chk("rst_cpu_reset_n", 64'(crn_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        chk("rst_status", 64'(status_a), 64'(ST_IDLE));
        chk("rst_cycle_count", 64'(cc_a), 64'(0));
        chk("rst_retire_count", 64'(rc_a), 64'(0));
        chk("rst_fail_code", 64'(fc_a), 64'(0));
        a_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rel_low_%0d", i), 64'(crn_a), 64'(0));
            tick();
        end
        chk("rel_high", 64'(crn_a), 64'(1));
        chk("rel_status", 64'(status_a), 64'(ST_RUNNING));
        chk("rel_cycle_count", 64'(cc_a), 64'(0));
        $display("reset sequence: cpu_reset_n=%0b status=%0d", crn_a, status_a);

        // Table of end-of-test stores
        for (int v = 0; v < 4; v++) begin
            start_run();
            for (int c = 0; c < vecs[v].n; c++) begin
                retire_valid = (c < vecs[v].r);
                tick();
            end
            retire_valid = vecs[v].ret_on_store;
            tohost_store(vecs[v].addr, vecs[v].data);
            tick();
            clear_inputs();
            chk($sformatf("v%0d_done", v), 64'(done_a), 64'(1));
            chk($sformatf("v%0d_status", v), 64'(status_a), 64'(vecs[v].exp_status));
            chk($sformatf("v%0d_fail_code", v), 64'(fc_a), 64'(vecs[v].exp_fc));
            chk($sformatf("v%0d_cycle_count", v), 64'(cc_a), 64'(vecs[v].exp_cc));
            chk($sformatf("v%0d_retire_count", v), 64'(rc_a), 64'(vecs[v].exp_rc));
            chk($sformatf("v%0d_cpu_reset_n", v), 64'(crn_a), 64'(0));
            retire_valid = 1'b1;
            tohost_store(TOHOST, 32'h1);
            repeat (3) tick();
            clear_inputs();
            chk($sformatf("v%0d_frozen_status", v), 64'(status_a), 64'(vecs[v].exp_status));
            chk($sformatf("v%0d_frozen_cc", v), 64'(cc_a), 64'(vecs[v].exp_cc));
            chk($sformatf("v%0d_frozen_rc", v), 64'(rc_a), 64'(vecs[v].exp_rc));
            $display("vector %0d: status=%0d fail_code=%0h cycles=%0d retires=%0d",
                     v, status_a, fc_a, cc_a, rc_a);
        end

        // Store of 1 to a neighbouring address is ignored
        start_run();
        tohost_store(TOHOST - 32'd4, 32'h1);
        tick();
        clear_inputs();
        chk("near_addr_done", 64'(done_a), 64'(0));
        chk("near_addr_status", 64'(status_a), 64'(ST_RUNNING));
        $display("near-address store: done=%0b status=%0d", done_a, status_a);

        // Watchdog timeout with retire every cycle
        start_run();
        retire_valid = 1'b1;
        cnt = 0;
        while (!done_t && cnt < 300) begin
            tick();
            cnt++;
        end
        clear_inputs();
        chk("wdog_cycles_to_done", 64'(cnt), 64'(100));
        chk("wdog_status", 64'(status_t), 64'(ST_TIMEOUT));
        chk("wdog_cycle_count", 64'(cc_t), 64'(100));
        chk("wdog_retire_count", 64'(rc_t), 64'(100));
        chk("wdog_cpu_reset_n", 64'(crn_t), 64'(0));
        $display("timeout: cycles=%0d status=%0d", cnt, status_t);

        // Hang after 8 RUN cycles with no retire
        start_run();
        cnt = 0;
        while (!done_h && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("hang_cycles_to_done", 64'(cnt), 64'(8));
        chk("hang_status", 64'(status_h), 64'(ST_HANG));
        chk("hang_cycle_count", 64'(cc_h), 64'(8));
        chk("hang_retire_count", 64'(rc_h), 64'(0));
        $display("hang: cycles=%0d status=%0d", cnt, status_h);

        // tohost store on the hang cycle wins
        start_run();
        repeat (7) tick();
        tohost_store(TOHOST, 32'h1);
        tick();
        clear_inputs();
        chk("prio_tohost_status", 64'(status_h), 64'(ST_PASS));
        chk("prio_tohost_cc", 64'(cc_h), 64'(8));
        $display("tohost vs hang: status=%0d", status_h);

        // Hang and watchdog fire on the same cycle: hang wins
        start_run();
        cnt = 0;
        while (!done_t && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("prio_hang_cycles", 64'(cnt), 64'(100));
        chk("prio_hang_status", 64'(status_t), 64'(ST_HANG));
        $display("hang vs timeout: status=%0d", status_t);

        // Rerun from DONE, then rerun ignored while running
        start_run();
        retire_valid = 1'b1;
        repeat (5) tick();
        tohost_store(TOHOST, 32'h1);
        tick();
        clear_inputs();
        chk("rerun_pre_done", 64'(done_a), 64'(1));
        rerun = 1'b1;
        tick();
        rerun = 1'b0;
        chk("rerun_done", 64'(done_a), 64'(0));
        chk("rerun_status", 64'(status_a), 64'(ST_IDLE));
        chk("rerun_cycle_count", 64'(cc_a), 64'(0));
        chk("rerun_retire_count", 64'(rc_a), 64'(0));
        chk("rerun_cpu_reset_n", 64'(crn_a), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rerun_low_%0d", i), 64'(crn_a), 64'(0));
        end
        tick();
        chk("rerun_high", 64'(crn_a), 64'(1));
        chk("rerun_running", 64'(status_a), 64'(ST_RUNNING));
        cc_snap = int'(cc_a);
        rerun = 1'b1;
        tick();
        rerun = 1'b0;
        chk("rerun_in_run_status", 64'(status_a), 64'(ST_RUNNING));
        chk("rerun_in_run_cc", 64'(cc_a), 64'(cc_snap + 1));
        $display("rerun: status=%0d cycles=%0d", status_a, cc_a);

        // Asynchronous reset mid-RUN takes effect before the next edge
        retire_valid = 1'b1;
        repeat (3) tick();
        retire_valid = 1'b0;
        a_reset_n = 1'b0;
        #1;
        chk("async_cpu_reset_n", 64'(crn_a), 64'(0));
        chk("async_status", 64'(status_a), 64'(ST_IDLE));
        chk("async_cycle_count", 64'(cc_a), 64'(0));
        chk("async_retire_count", 64'(rc_a), 64'(0));
        chk("async_done", 64'(done_a), 64'(0));
        $display("async reset: status=%0d cycles=%0d", status_a, cc_a);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
